// File: rtl/ifetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl_if
//  Description : Instruction-memory request port and decode-side handshake
//                bundled for the instruction-fetch responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_ctrl_if #(
    parameter int DATA_W = 32
);
    // Instruction-memory port (req/gnt/rvalid, in-order responses)
    logic              imem_req_o;
    logic [DATA_W-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DATA_W-1:0] imem_rdata_i;

    // Decode-side valid/ready handshake
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [DATA_W-1:0] inst_pc_o;
    logic              inst_ready_i;

    // Fetch unit side
    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output inst_valid_o, inst_o, inst_pc_o,
        input  inst_ready_i
    );

    // Memory / decode side
    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  inst_valid_o, inst_o, inst_pc_o,
        output inst_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl
//  Description : Instruction-fetch responder. Issues in-order fetches for the
//                current PC, queues returned words with their PCs and hands
//                them to decode; squashes in-flight fetches on a redirect.
//                DEPTH must be 2 or 4 (power of two, pointers wrap freely).
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  wire               clk_i,
    input  wire               rst_n_i,
    input  wire  [DATA_W-1:0] pc_i,
    input  wire               flush_i,
    output logic              hold_flag_o,
    ifetch_ctrl_if.master     bus
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam int c_cnt_w1 = c_cnt_w + 1;

    // Queue storage: one slot per outstanding fetch
    logic [DATA_W-1:0]  r_pc   [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_filled;

    logic [c_ptr_w-1:0] r_alloc_ptr;
    logic [c_ptr_w-1:0] r_fill_ptr;
    logic [c_ptr_w-1:0] r_head_ptr;
    logic [c_cnt_w-1:0] r_alloc_cnt;
    logic [c_cnt_w-1:0] r_drop_cnt;
    logic               r_started;

    logic               w_pop;
    logic               w_req;
    logic               w_accept;
    logic               w_fill;
    logic               w_drop;
    logic [c_cnt_w-1:0] w_filled_cnt;
    logic [c_cnt_w-1:0] w_unfilled;
    logic [c_cnt_w-1:0] w_drop_sum;
    logic [c_cnt_w-1:0] w_flush_drop;
    logic [c_cnt_w:0]   w_credit_used;

    // Count slots already holding a returned word
    always_comb begin
        w_filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_filled_cnt = w_filled_cnt + c_cnt_w'(r_filled[i]);
        end
    end

    // Allocated slots still waiting for their response
    assign w_unfilled = r_alloc_cnt - w_filled_cnt;

    // Decode handshake; a redirect hides the head so nothing pops in that cycle
    assign bus.inst_valid_o = r_filled[r_head_ptr] & ~flush_i;
    assign bus.inst_o       = r_data[r_head_ptr];
    assign bus.inst_pc_o    = r_pc[r_head_ptr];
    assign w_pop            = bus.inst_valid_o & bus.inst_ready_i;

    // Credit counts live slots plus responses still owed to the discard path;
    // a same-cycle pop returns its slot so a 1-cycle memory can stream.
    assign w_credit_used = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt}
                         - c_cnt_w1'(w_pop);
    assign w_req         = r_started & ~flush_i & (w_credit_used < c_cnt_w1'(DEPTH));
    assign w_accept      = w_req & bus.imem_gnt_i;

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = pc_i;
    assign hold_flag_o     = ~w_accept;

    // Responses go to the discard path first; a stray one with nothing owed is ignored
    assign w_drop = bus.imem_rvalid_i & (r_drop_cnt != '0);
    assign w_fill = bus.imem_rvalid_i & (r_drop_cnt == '0) & (w_unfilled != '0);

    // On redirect every unfilled slot becomes a response to discard, minus
    // one if that response is arriving right now (it is pre-redirect traffic)
    assign w_drop_sum   = r_drop_cnt + w_unfilled;
    assign w_flush_drop = (bus.imem_rvalid_i && (w_drop_sum != '0))
                        ? w_drop_sum - c_cnt_w'(1) : w_drop_sum;

    // Start-up flag: requests are held off for the first cycle out of reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    // Queue pointers, occupancy and discard bookkeeping
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_alloc_cnt <= '0;
            r_drop_cnt  <= '0;
        end else if (flush_i) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_alloc_cnt <= '0;
            r_drop_cnt  <= w_flush_drop;
        end else begin
            if (w_accept) r_alloc_ptr <= r_alloc_ptr + c_ptr_w'(1);
            if (w_fill)   r_fill_ptr  <= r_fill_ptr + c_ptr_w'(1);
            if (w_pop)    r_head_ptr  <= r_head_ptr + c_ptr_w'(1);
            if (w_drop)   r_drop_cnt  <= r_drop_cnt - c_cnt_w'(1);
            r_alloc_cnt <= r_alloc_cnt + c_cnt_w'(w_accept) - c_cnt_w'(w_pop);
        end
    end

    // Slot contents: PC on accept, word on fill, filled flag tracks both plus pop
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_data[i] <= '0;
            end
            r_filled <= '0;
        end else if (flush_i) begin
            r_filled <= '0;
        end else begin
            if (w_pop) begin
                r_filled[r_head_ptr] <= 1'b0;
            end
            if (w_accept) begin
                r_pc[r_alloc_ptr]     <= pc_i;
                r_filled[r_alloc_ptr] <= 1'b0;
            end
            if (w_fill) begin
                r_data[r_fill_ptr]   <= bus.imem_rdata_i;
                r_filled[r_fill_ptr] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_ctrl
//  Description : Directed self-checking bench for ifetch_ctrl with a PC
//                generator model and a fixed-latency in-order memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] pc;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] flush_pc = '0;
    logic              hold;

    int checks = 0;
    int errors = 0;

    ifetch_ctrl_if #(.DATA_W(DATA_W)) bus ();

    ifetch_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .pc_i        (pc),
        .flush_i     (flush),
        .hold_flag_o (hold),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // PC generator: loads the redirect target on flush, advances on accepted fetch
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pc <= '0;
        else if (flush) pc <= flush_pc;
        else if (!hold) pc <= pc + 32'd4;
    end

    // Memory: returns the address as data, mem_lat cycles after acceptance
    logic [DATA_W-1:0] mq_addr[$];
    int                mq_due[$];
    int                cyc = 0;
    int                mem_lat = 1;

    always @(posedge clk) begin : mem_model
        logic              acc;
        logic [DATA_W-1:0] a;
        acc = rst_n && bus.imem_req_o && bus.imem_gnt_i;
        a   = bus.imem_addr_o;
        #1;
        cyc = cyc + 1;
        if (bus.imem_rvalid_i && mq_due.size() > 0) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
        end else if (acc) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc - 1 + mem_lat);
        end
        if (rst_n && mq_due.size() > 0 && mq_due[0] <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mq_addr[0];
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end
    end

    // A response with nothing allocated-and-unfilled and nothing owed is illegal
    always @(negedge clk) begin
        if (rst_n && bus.imem_rvalid_i) begin
            assert ((dut.r_drop_cnt != '0) || (dut.w_unfilled != '0))
                else $error("protocol violation: response with nothing outstanding");
        end
    end

    // Sample point: 3 time units after the rising edge
    task automatic step();
        @(posedge clk); #3;
    endtask

    // Drive point: 2 time units after the rising edge
    task automatic drv();
        @(posedge clk); #2;
    endtask

    // Reset for two edges and release at the drive point of cycle R
    task automatic do_reset();
        drv(); rst_n = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.imem_gnt_i = 1'b1; bus.inst_ready_i = 1'b1; mem_lat = 1;
        repeat (2) @(posedge clk);
        #3;
        checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", bus.inst_valid_o); end
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%0b exp=0", bus.imem_req_o); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rst_hold got=%0b exp=1", hold); end
        checks++; if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=0", bus.inst_o); end
        checks++; if (bus.inst_pc_o !== 32'h0) begin errors++; $display("FAIL rst_inst_pc got=%h exp=0", bus.inst_pc_o); end
        checks++; if (dut.r_drop_cnt !== '0) begin errors++; $display("FAIL rst_drop got=%0d exp=0", dut.r_drop_cnt); end
        // cycle R: released, not yet started
        drv(); rst_n = 1'b1; #1;
        checks++; if (bus.imem_req_o !== 1'b0 || hold !== 1'b1) begin errors++; $display("FAIL startup_idle req=%0b hold=%0b exp req=0 hold=1", bus.imem_req_o, hold); end
        step(); // R+1
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0 || hold !== 1'b0) begin errors++; $display("FAIL startup_req0 req=%0b addr=%h hold=%0b exp 1/0/0", bus.imem_req_o, bus.imem_addr_o, hold); end
        step(); // R+2
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4 || bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL startup_req4 req=%0b addr=%h valid=%0b exp 1/4/0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o); end
        step(); // R+3
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8) begin errors++; $display("FAIL startup_req8 req=%0b addr=%h exp 1/8", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    // Continues from R+3: first valid 2 cycles after the first accept, then 1/cycle
    task automatic test_streaming();
        logic [DATA_W-1:0] exp;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            exp = 32'(4 * i);
            checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== exp || bus.inst_o !== exp) begin errors++; $display("FAIL stream[%0d] valid=%0b pc=%h inst=%h exp valid=1 pc=inst=%h", i, bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] exp;
        drv(); bus.inst_ready_i = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++; if (bus.imem_req_o !== 1'b0 || hold !== 1'b1 || bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h20) begin errors++; $display("FAIL bp_stall[%0d] req=%0b hold=%0b valid=%0b pc=%h exp 0/1/1/20", i, bus.imem_req_o, hold, bus.inst_valid_o, bus.inst_pc_o); end
        end
        drv(); bus.inst_ready_i = 1'b1; #1;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h28 || hold !== 1'b0) begin errors++; $display("FAIL bp_resume_req req=%0b addr=%h hold=%0b exp 1/28/0", bus.imem_req_o, bus.imem_addr_o, hold); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            exp = 32'h20 + 32'(4 * i);
            checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== exp || bus.inst_o !== exp) begin errors++; $display("FAIL bp_resume[%0d] valid=%0b pc=%h inst=%h exp pc=inst=%h", i, bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, exp); end
        end
    endtask

    // Asynchronous reset while streaming clears outputs without a clock edge
    task automatic test_reset_midop();
        drv(); rst_n = 1'b0; #1;
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0 || hold !== 1'b1) begin errors++; $display("FAIL midrst_ctrl valid=%0b req=%0b hold=%0b exp 0/0/1", bus.inst_valid_o, bus.imem_req_o, hold); end
        checks++; if (bus.inst_o !== 32'h0 || bus.inst_pc_o !== 32'h0) begin errors++; $display("FAIL midrst_data inst=%h pc=%h exp 0/0", bus.inst_o, bus.inst_pc_o); end
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1; #1;
    endtask

    // Continues from cycle R after reset release; gnt low while pc_i = 0x10
    task automatic test_grant_stall();
        repeat (4) step(); // R+4
        drv(); bus.imem_gnt_i = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++; if (hold !== 1'b1 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin errors++; $display("FAIL gnt_stall[%0d] hold=%0b req=%0b addr=%h exp 1/1/10", i, hold, bus.imem_req_o, bus.imem_addr_o); end
        end
        drv(); bus.imem_gnt_i = 1'b1; #1; // R+8
        checks++; if (hold !== 1'b0 || bus.imem_addr_o !== 32'h10) begin errors++; $display("FAIL gnt_refetch hold=%0b addr=%h exp 0/10", hold, bus.imem_addr_o); end
        step(); // R+9
        checks++; if (hold !== 1'b0 || bus.imem_addr_o !== 32'h14) begin errors++; $display("FAIL gnt_next hold=%0b addr=%h exp 0/14", hold, bus.imem_addr_o); end
        step(); // R+10
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h10 || bus.inst_o !== 32'h10) begin errors++; $display("FAIL gnt_deliver valid=%0b pc=%h inst=%h exp 1/10/10", bus.inst_valid_o, bus.inst_pc_o, bus.inst_o); end
    endtask

    // Two fetches (0x20, 0x24) in flight on a 3-cycle memory, redirect to 0x100
    task automatic test_flush_inflight();
        mem_lat = 3;
        do_reset(); flush = 1'b1; flush_pc = 32'h20; #1; // R
        drv(); flush = 1'b0; #1;                          // R+1
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h20) begin errors++; $display("FAIL fl_req20 req=%0b addr=%h exp 1/20", bus.imem_req_o, bus.imem_addr_o); end
        step();                                           // R+2
        checks++; if (bus.imem_addr_o !== 32'h24 || hold !== 1'b0) begin errors++; $display("FAIL fl_req24 addr=%h hold=%0b exp 24/0", bus.imem_addr_o, hold); end
        drv(); flush = 1'b1; flush_pc = 32'h100; #1;      // R+3
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0 || hold !== 1'b1) begin errors++; $display("FAIL fl_cycle valid=%0b req=%0b hold=%0b exp 0/0/1", bus.inst_valid_o, bus.imem_req_o, hold); end
        drv(); flush = 1'b0; #1;                          // R+4
        checks++; if (dut.r_drop_cnt !== 2'd2 || bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL fl_drop2 drop=%0d req=%0b exp 2/0", dut.r_drop_cnt, bus.imem_req_o); end
        step();                                           // R+5
        checks++; if (dut.r_drop_cnt !== 2'd1 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin errors++; $display("FAIL fl_req100 drop=%0d req=%0b addr=%h exp 1/1/100", dut.r_drop_cnt, bus.imem_req_o, bus.imem_addr_o); end
        for (int i = 0; i < 3; i++) begin                 // R+6..R+8
            step();
            checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL fl_quiet[%0d] valid=%0b exp 0", i, bus.inst_valid_o); end
        end
        step();                                           // R+9
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h100 || bus.inst_o !== 32'h100) begin errors++; $display("FAIL fl_first valid=%0b pc=%h inst=%h exp 1/100/100", bus.inst_valid_o, bus.inst_pc_o, bus.inst_o); end
        step();                                           // R+10
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h104) begin errors++; $display("FAIL fl_second valid=%0b pc=%h exp 1/104", bus.inst_valid_o, bus.inst_pc_o); end
    endtask

    // Redirect lands in the same cycle as the response for 0x40
    task automatic test_flush_rvalid();
        mem_lat = 3;
        do_reset(); flush = 1'b1; flush_pc = 32'h40; #1; // R
        drv(); flush = 1'b0; #1;                          // R+1
        repeat (2) step();                                // R+3
        drv(); flush = 1'b1; flush_pc = 32'h200; #1;      // R+4
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL flrv_cycle valid=%0b req=%0b exp 0/0", bus.inst_valid_o, bus.imem_req_o); end
        drv(); flush = 1'b0; #1;                          // R+5
        checks++; if (dut.r_drop_cnt !== 2'd1) begin errors++; $display("FAIL flrv_drop drop=%0d exp 1", dut.r_drop_cnt); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin errors++; $display("FAIL flrv_req req=%0b addr=%h exp 1/200", bus.imem_req_o, bus.imem_addr_o); end
        step();                                           // R+6
        checks++; if (dut.r_drop_cnt !== 2'd0 || bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL flrv_drained drop=%0d valid=%0b exp 0/0", dut.r_drop_cnt, bus.inst_valid_o); end
        repeat (3) step();                                // R+9
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h200 || bus.inst_o !== 32'h200) begin errors++; $display("FAIL flrv_first valid=%0b pc=%h inst=%h exp 1/200/200", bus.inst_valid_o, bus.inst_pc_o, bus.inst_o); end
    endtask

    // Redirect while the head is filled and decode is stalled
    task automatic test_flush_filled();
        mem_lat = 1; bus.inst_ready_i = 1'b0;
        do_reset(); #1;                                   // R
        repeat (3) step();                                // R+3
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h0) begin errors++; $display("FAIL ff_pre valid=%0b pc=%h exp 1/0", bus.inst_valid_o, bus.inst_pc_o); end
        drv(); flush = 1'b1; flush_pc = 32'h300; #1;      // R+4
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0 || hold !== 1'b1) begin errors++; $display("FAIL ff_cycle valid=%0b req=%0b hold=%0b exp 0/0/1", bus.inst_valid_o, bus.imem_req_o, hold); end
        drv(); flush = 1'b0; bus.inst_ready_i = 1'b1; #1; // R+5
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h300 || dut.r_drop_cnt !== 2'd0) begin errors++; $display("FAIL ff_after valid=%0b req=%0b addr=%h drop=%0d exp 0/1/300/0", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o, dut.r_drop_cnt); end
        repeat (2) step();                                // R+7
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h300 || bus.inst_o !== 32'h300) begin errors++; $display("FAIL ff_first valid=%0b pc=%h inst=%h exp 1/300/300", bus.inst_valid_o, bus.inst_pc_o, bus.inst_o); end
    endtask

    initial begin
        bus.imem_gnt_i    = 1'b1;
        bus.inst_ready_i  = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_reset_midop();
        test_grant_stall();
        test_flush_inflight();
        test_flush_rvalid();
        test_flush_filled();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
